// File: rtl/mont_reduce_arbiter.sv
// Two-requester round-robin front end for a single shared Montgomery reducer.
// One transaction in flight: accept in IDLE, pulse start, wait for done or timeout, answer the winner.
module mont_reduce_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid0,
  input  logic               req_valid1,
  input  logic signed [63:0] req_a0,
  input  logic signed [63:0] req_a1,
  output logic               req_ready0,
  output logic               req_ready1,
  output logic               rsp_valid0,
  output logic               rsp_valid1,
  output logic signed [31:0] rsp_t0,
  output logic signed [31:0] rsp_t1,
  output logic               mr_start,
  output logic signed [63:0] mr_a,
  input  logic               mr_done,
  input  logic signed [31:0] mr_t,
  output logic               busy,
  output logic               err,
  output logic        [15:0] op_count
);

  localparam int unsigned AW  = 64;
  localparam int unsigned TW  = 32;
  localparam int unsigned OCW = 16;
  localparam int unsigned CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q;
  logic                  grant_q;
  logic                  last_q;
  logic [CW-1:0]         wait_cnt_q;
  logic                  mr_start_q;
  logic signed [AW-1:0]  mr_a_q;
  logic                  rsp_valid0_q;
  logic                  rsp_valid1_q;
  logic signed [TW-1:0]  rsp_t0_q;
  logic signed [TW-1:0]  rsp_t1_q;
  logic                  busy_q;
  logic                  err_q;
  logic [OCW-1:0]        op_count_q;

  logic                  win1_d;
  logic                  accept_d;
  logic                  timeout_d;

  // Requester 1 wins alone, or on a tie when requester 0 was granted last.
  always_comb begin
    win1_d    = req_valid1 & (~req_valid0 | ~last_q);
    accept_d  = reset & (state_q == IDLE) & (req_valid0 | req_valid1);
    timeout_d = (wait_cnt_q == CW'(TIMEOUT - 1));
  end

  assign req_ready0 = accept_d & ~win1_d;
  assign req_ready1 = accept_d & win1_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_q       <= 1'b1;
      wait_cnt_q   <= '0;
      mr_start_q   <= 1'b0;
      mr_a_q       <= '0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_t0_q     <= '0;
      rsp_t1_q     <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      op_count_q   <= '0;
    end else begin
      mr_start_q   <= 1'b0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_t0_q     <= '0;
      rsp_t1_q     <= '0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            grant_q    <= win1_d;
            mr_a_q     <= win1_d ? req_a1 : req_a0;
            mr_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          // done beats a coincident timeout
          if (mr_done) begin
            mr_a_q       <= '0;
            rsp_valid0_q <= ~grant_q;
            rsp_valid1_q <= grant_q;
            rsp_t0_q     <= grant_q ? TW'(0) : mr_t;
            rsp_t1_q     <= grant_q ? mr_t : TW'(0);
            op_count_q   <= op_count_q + OCW'(1);
            state_q      <= RESP;
          end else if (timeout_d) begin
            mr_a_q       <= '0;
            rsp_valid0_q <= ~grant_q;
            rsp_valid1_q <= grant_q;
            err_q        <= 1'b1;
            state_q      <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        RESP: begin
          last_q  <= grant_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mr_start   = mr_start_q;
  assign mr_a       = mr_a_q;
  assign rsp_valid0 = rsp_valid0_q;
  assign rsp_valid1 = rsp_valid1_q;
  assign rsp_t0     = rsp_t0_q;
  assign rsp_t1     = rsp_t1_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_mont_reduce_arbiter.sv
// Bench for mont_reduce_arbiter: directed scenarios plus random traffic against a
// transaction-level model (round-robin rule, Montgomery arithmetic, timeout rule).
module tb_mont_reduce_arbiter;

  localparam int TIMEOUT = 16;

  logic               clock = 1'b0;
  logic               reset;
  logic               req_valid0, req_valid1;
  logic signed [63:0] req_a0, req_a1;
  logic               req_ready0, req_ready1;
  logic               rsp_valid0, rsp_valid1;
  logic signed [31:0] rsp_t0, rsp_t1;
  logic               mr_start;
  logic signed [63:0] mr_a;
  logic               mr_done;
  logic signed [31:0] mr_t;
  logic               busy, err;
  logic        [15:0] op_count;

  int n_chk = 0;
  int n_pass = 0;

  // model state
  bit        m_last;
  bit        m_err;
  bit [15:0] m_ops;
  int        obs_rsp0, obs_rsp1;

  // reducer model controls and state
  int                 rm_lat;
  bit                 rm_hang;
  int                 rm_cnt = 0;
  logic signed [63:0] rm_a = '0;

  mont_reduce_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_a0(req_a0), .req_a1(req_a1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_t0(rsp_t0), .rsp_t1(rsp_t1),
    .mr_start(mr_start), .mr_a(mr_a),
    .mr_done(mr_done), .mr_t(mr_t),
    .busy(busy), .err(err), .op_count(op_count)
  );

  always #5 clock = ~clock;

  // Dilithium Montgomery reduce: (a - ((int32)(a*QINV))*Q) >> 32
  function automatic logic signed [31:0] mont(input logic signed [63:0] a);
    longint p, r;
    int     t;
    p = longint'($signed(a[31:0])) * 64'sd58728449;
    t = int'(p[31:0]);
    r = (longint'(a) - longint'(t) * 64'sd8380417) >>> 32;
    return r[31:0];
  endfunction

  // Reducer: done pulses rm_lat cycles after the start cycle; ignores the arbiter's reset.
  always @(posedge clock) begin
    if (mr_start) begin
      rm_cnt <= rm_hang ? 0 : rm_lat;
      rm_a   <= mr_a;
    end else if (rm_cnt != 0) begin
      rm_cnt <= rm_cnt - 1;
    end
  end
  assign mr_done = (rm_cnt == 1);
  assign mr_t    = mont(rm_a);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({req_ready0, req_ready1, rsp_valid0, rsp_valid1, mr_start, busy, err}), 64'd0);
    chk({tag, "_rsp_t"}, {rsp_t0, rsp_t1}, 64'd0);
    chk({tag, "_mr_a"}, mr_a, 64'd0);
    chk({tag, "_op_count"}, 64'(op_count), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0;
    #1 chk_zero(tag);
    repeat (2) @(negedge clock);
    chk_zero({tag, "_held"});
    reset = 1'b1;
    m_last = 1'b1; m_err = 1'b0; m_ops = '0;
  endtask

  // One full transaction from the accept cycle through the response cycle.
  task automatic txn(input bit v0, input bit v1, input logic signed [63:0] a0,
                     input logic signed [63:0] a1, input int lat, input bit hang, input bit hold);
    bit                 w, to;
    int                 nwait;
    logic signed [63:0] wa;
    logic signed [31:0] et;
    @(negedge clock);
    req_valid0 = v0; req_valid1 = v1; req_a0 = a0; req_a1 = a1;
    rm_lat = lat; rm_hang = hang;
    w     = (v0 && v1) ? ~m_last : v1;
    wa    = w ? a1 : a0;
    to    = hang || (lat > TIMEOUT);
    nwait = to ? TIMEOUT : lat;
    et    = to ? 32'sd0 : mont(wa);
    #1;
    chk("accept_ready", 64'({req_ready0, req_ready1}), w ? 64'd1 : 64'd2);
    chk("accept_busy", 64'(busy), 64'd0);
    @(negedge clock);
    if (!hold) begin req_valid0 = 1'b0; req_valid1 = 1'b0; end
    chk("issue_ctl", 64'({mr_start, busy, req_ready0, req_ready1, rsp_valid0, rsp_valid1}), 64'h30);
    chk("issue_mr_a", mr_a, wa);
    for (int i = 0; i < nwait; i++) begin
      @(negedge clock);
      chk("wait_ctl", 64'({mr_start, busy, req_ready0, req_ready1, rsp_valid0, rsp_valid1}), 64'h10);
      chk("wait_mr_a", mr_a, wa);
    end
    @(negedge clock);
    if (to) m_err = 1'b1;
    else    m_ops = m_ops + 16'd1;
    chk("resp_valid", 64'({rsp_valid0, rsp_valid1}), w ? 64'd1 : 64'd2);
    chk("resp_t0", 64'(rsp_t0), w ? 64'd0 : 64'(et));
    chk("resp_t1", 64'(rsp_t1), w ? 64'(et) : 64'd0);
    chk("resp_op_count", 64'(op_count), 64'(m_ops));
    chk("resp_err", 64'(err), 64'(m_err));
    chk("resp_ctl", 64'({busy, req_ready0, req_ready1, mr_start}), 64'h8);
    if (rsp_valid0) obs_rsp0++;
    if (rsp_valid1) obs_rsp1++;
    m_last = w;
  endtask

  initial begin
    logic signed [63:0] ra0, ra1;
    bit                 rv0, rv1;
    reset = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0; req_a0 = '0; req_a1 = '0;
    rm_lat = 2; rm_hang = 1'b0;
    m_last = 1'b1; m_err = 1'b0; m_ops = '0;
    #1 chk_zero("rst_init");
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Scenario 1: lone request, latency 3, known result -114592
    txn(1, 0, 64'sd1, 64'sd0, 3, 0, 0);
    chk("s1_result", 64'(mont(64'sd1)), 64'(-32'sd114592));

    // Scenario 2: tie after reset goes to 0, then 1, then the next tie to 0
    do_reset("rst_s2");
    txn(1, 1, 64'sd0, 64'sd4294967296, 4, 0, 1);
    txn(0, 1, 64'sd0, 64'sd4294967296, 2, 0, 0);
    txn(1, 1, 64'sd7, 64'sd9, 2, 0, 0);

    // Scenario 3: both held valid for 8 transactions
    do_reset("rst_s3");
    obs_rsp0 = 0; obs_rsp1 = 0;
    for (int i = 0; i < 8; i++) begin
      ra0 = longint'($signed($urandom)) * longint'($urandom_range(0, 8380416));
      ra1 = longint'($signed($urandom)) * longint'($urandom_range(0, 8380416));
      txn(1, 1, ra0, ra1, $urandom_range(2, 6), 0, 1);
    end
    chk("s3_rsp0_count", 64'(obs_rsp0), 64'd4);
    chk("s3_rsp1_count", 64'(obs_rsp1), 64'd4);
    chk("s3_op_count", 64'(op_count), 64'd8);

    // Boundaries: minimum latency, done on the timeout cycle, then timeout and sticky err
    txn(1, 0, 64'sd123456789, 64'sd0, 2, 0, 0);
    txn(0, 1, 64'sd0, -64'sd987654321, TIMEOUT, 0, 0);
    txn(1, 0, 64'sd55, 64'sd0, 0, 1, 0);
    txn(0, 1, 64'sd0, 64'sd77, 5, 0, 0);
    chk("err_sticky", 64'(err), 64'd1);

    // Scenario 5: reset during WAIT, stale done after release
    @(negedge clock);
    req_valid0 = 1'b1; req_a0 = 64'sd1000; rm_lat = 10; rm_hang = 1'b0;
    @(negedge clock);
    req_valid0 = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0; req_valid0 = 1'b1;
    #1 chk_zero("s5_rst");
    @(negedge clock);
    chk_zero("s5_rst_held");
    req_valid0 = 1'b0;
    reset = 1'b1;
    m_last = 1'b1; m_err = 1'b0; m_ops = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("s5_quiet", 64'({rsp_valid0, rsp_valid1, busy, mr_start, err}), 64'd0);
    end
    txn(1, 0, -64'sd31337, 64'sd0, 4, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 24; i++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
      ra0 = longint'($signed($urandom)) * longint'($urandom_range(0, 8380416));
      ra1 = longint'($signed($urandom)) * longint'($urandom_range(0, 8380416));
      txn(rv0, rv1, ra0, ra1, $urandom_range(2, TIMEOUT), ($urandom_range(0, 7) == 0), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
